// File: rtl/gate_vector_checker.sv
// -----------------------------------------------------------------------------
// gate_vector_checker
//
// Hardware stimulus-and-check engine for a two-input gates block. After a
// start request it walks {a,b} through 00, 01, 10, 11. Each vector is held
// for HOLD_CYCLES drive cycles plus one check cycle. In the check cycle the
// seven gate outputs are compared against golden values. Per-run results are
// kept until the next start or reset.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  run request, sampled only while idle
//   a, b       out  1  stimulus to the gates block
//   y_in       in   7  gate outputs {and,or,not,nand,nor,xor,xnor}
//                      ([6]=and ... [0]=xnor, not = ~a)
//   busy       out  1  run in progress (drive or check)
//   done       out  1  one-cycle pulse at the end of a run
//   pass       out  1  1 iff no vector miscompared (valid from done)
//   err_count  out  3  number of vectors with any miscompare (0..4)
//   fail_vec   out  4  bit i set if vector i = {a,b} miscompared
//   miss_mask  out  7  sticky OR of (y_in ^ expected) over the run
// -----------------------------------------------------------------------------
module gate_vector_checker #(
    parameter int HOLD_CYCLES = 5,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [6:0] miss_mask
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    err_q, err_d;
    logic [3:0]    fail_q, fail_d;
    logic [6:0]    miss_q, miss_d;
    logic          pass_q, pass_d;
    logic [6:0]    diff;

    // Golden gate outputs for a vector v = {a,b}.
    function automatic logic [6:0] golden(input logic [1:0] v);
        logic ga, gb;
        ga = v[1];
        gb = v[0];
        return {ga & gb, ga | gb, ~ga, ~(ga & gb), ~(ga | gb), ga ^ gb, ~(ga ^ gb)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            miss_q  <= 7'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            miss_q  <= miss_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        miss_d  = miss_q;
        pass_d  = pass_q;
        diff    = 7'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    miss_d  = 7'd0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = RELOAD;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Counter is loaded with HOLD_CYCLES-1, so the edge that sees
                // zero ends exactly HOLD_CYCLES drive cycles.
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CHECK: begin
                diff = y_in ^ golden(vec_q);
                if (diff != 7'd0) begin
                    // At most four vectors can fail, so the 3-bit count never wraps.
                    err_d         = err_q + 3'd1;
                    fail_d[vec_q] = 1'b1;
                    miss_d        = miss_q | diff;
                end
                if (vec_q == 2'd3) begin
                    pass_d  = (err_d == 3'd0);
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = RELOAD;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stimulus is only driven while a run is active; idle and done show 00.
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign a         = busy & vec_q[1];
    assign b         = busy & vec_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
    assign miss_mask = miss_q;

endmodule
